// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL bus types, opcodes and the bridge's request-tracking entry.
package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
  typedef enum logic [2:0] {PutFullData = 3'h0, PutPartialData = 3'h1, Get = 3'h4} tl_a_op_e;
  typedef enum logic [2:0] {AccessAck = 3'h0, AccessAckData = 3'h1} tl_d_op_e;
  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [0:0]        d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
  typedef struct packed {
    logic              is_read;
    logic              err;
    logic [TL_SZW-1:0] size;
    logic [TL_AIW-1:0] source;
  } req_entry_t;
  // Byte lanes covered by an access of 2**size bytes at byte offset off
  function automatic logic [TL_DBW-1:0] size_mask(input logic [TL_SZW-1:0] size, input logic [1:0] off);
    return size == 2'd0 ? 4'b0001 << off : size == 2'd1 ? 4'b0011 << off : 4'b1111;
  endfunction
endpackage

// File: rtl/tlul_sram_bridge_if.sv
// tlul_sram_bridge_if: bundle of the TL-UL and SRAM signals surrounding the bridge.
interface tlul_sram_bridge_if #(parameter int SramAw = 10, parameter int SramDw = tlul_pkg::TL_DW);
  import tlul_pkg::*;
  tl_h2d_t           h2d;
  tl_d2h_t           d2h;
  logic              req;
  logic              gnt;
  logic              we;
  logic [SramAw-1:0] addr;
  logic [SramDw-1:0] wdata;
  logic [SramDw-1:0] wmask;
  logic [SramDw-1:0] rdata;
  logic              rvalid;
  logic [1:0]        rerror;
  modport master (output h2d, gnt, rdata, rvalid, rerror, input d2h, req, we, addr, wdata, wmask);
  modport slave (input h2d, gnt, rdata, rvalid, rerror, output d2h, req, we, addr, wdata, wmask);
endinterface

// File: rtl/prim_fifo_sync.sv
// prim_fifo_sync: synchronous FIFO with registered storage and optional pass-through when empty.
module prim_fifo_sync #(
  parameter int Width = 8,
  parameter bit Pass  = 1'b0,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o
);
  localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic empty, bypass, push, pop;
  assign empty    = cnt_q == '0;
  assign bypass   = Pass & empty;
  assign wready_o = cnt_q != CntW'(Depth);
  assign rvalid_o = ~empty | (bypass & wvalid_i);
  assign rdata_o  = bypass ? wdata_i : mem_q[rptr_q];
  assign push     = wvalid_i & wready_o & ~(bypass & rready_i);
  assign pop      = rvalid_o & rready_i & ~bypass;
  assign wptr_d   = push ? (wptr_q == PtrW'(Depth - 1) ? '0 : wptr_q + 1'b1) : wptr_q;
  assign rptr_d   = pop ? (rptr_q == PtrW'(Depth - 1) ? '0 : rptr_q + 1'b1) : rptr_q;
  assign cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/tlul_sram_bridge.sv
// tlul_sram_bridge: TL-UL device endpoint turning Get/Put requests into SRAM req/gnt
// transactions with in-order AccessAck/AccessAckData responses.
module tlul_sram_bridge
  import tlul_pkg::*;
#(
  parameter int SramAw      = 10,
  parameter int SramDw      = TL_DW,
  parameter int Outstanding = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tl_h2d_t           tl_i,
  output tl_d2h_t           tl_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [SramAw-1:0] addr_o,
  output logic [SramDw-1:0] wdata_o,
  output logic [SramDw-1:0] wmask_o,
  input  logic [SramDw-1:0] rdata_i,
  input  logic              rvalid_i,
  input  logic [1:0]        rerror_i
);
  localparam int CntW = $clog2(Outstanding + 1);
  logic is_get, is_put, err, full, a_ready, a_ack, rd_gnt, rd_push;
  logic rq_wready, rq_rvalid, rq_pop, rd_wready, rd_rvalid, rd_pop, good_rd, d_valid;
  logic [TL_DBW-1:0] need;
  logic [CntW-1:0] rd_pending_q, rd_pending_d;
  req_entry_t rq_in, rq_head;
  logic [SramDw:0] rd_head;
  logic unused_sig;
  assign is_get = tl_i.a_opcode == Get;
  assign is_put = tl_i.a_opcode inside {PutFullData, PutPartialData};
  assign need   = size_mask(tl_i.a_size, tl_i.a_address[1:0]);
  assign err    = ~(is_get | is_put) | (tl_i.a_size > 2'd2)
                | (tl_i.a_size == 2'd1 & tl_i.a_address[0])
                | (tl_i.a_size == 2'd2 & |tl_i.a_address[1:0])
                | (|tl_i.a_address[TL_AW-1:SramAw+2])
                | (tl_i.a_opcode == PutFullData & (tl_i.a_mask & need) != need)
                | (tl_i.a_mask == '0);
  assign full    = ~rq_wready;
  assign a_ready = ~full & (err | gnt_i);
  assign a_ack   = tl_i.a_valid & a_ready;
  assign req_o   = tl_i.a_valid & ~err & ~full;
  assign we_o    = tl_i.a_valid & is_put;
  assign addr_o  = tl_i.a_valid ? tl_i.a_address[SramAw+1:2] : '0;
  assign wdata_o = tl_i.a_valid ? tl_i.a_data : '0;
  for (genvar b = 0; b < TL_DBW; b++) begin : g_mask
    assign wmask_o[8*b +: 8] = {8{tl_i.a_valid & tl_i.a_mask[b]}};
  end
  // Only reads that were actually granted may claim returning rvalid beats
  assign rd_gnt       = req_o & gnt_i & is_get;
  assign rd_push      = rvalid_i & (rd_pending_q != '0);
  assign rd_pending_d = rd_pending_q + CntW'(rd_gnt) - CntW'(rd_push);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_pending_q <= '0;
    else rd_pending_q <= rd_pending_d;
  end
  assign rq_in = '{is_read: is_get, err: err, size: tl_i.a_size, source: tl_i.a_source};
  prim_fifo_sync #(.Width($bits(req_entry_t)), .Pass(1'b0), .Depth(Outstanding)) u_req_fifo (
    .clk_i, .rst_i, .wvalid_i(a_ack), .wready_o(rq_wready), .wdata_i(rq_in),
    .rvalid_o(rq_rvalid), .rready_i(rq_pop), .rdata_o(rq_head)
  );
  prim_fifo_sync #(.Width(SramDw + 1), .Pass(1'b0), .Depth(Outstanding)) u_rd_fifo (
    .clk_i, .rst_i, .wvalid_i(rd_push), .wready_o(rd_wready), .wdata_i({rdata_i, |rerror_i}),
    .rvalid_o(rd_rvalid), .rready_i(rd_pop), .rdata_o(rd_head)
  );
  assign good_rd = rq_head.is_read & ~rq_head.err;
  assign d_valid = rq_rvalid & (~good_rd | rd_rvalid);
  assign rq_pop  = d_valid & tl_i.d_ready;
  assign rd_pop  = rq_pop & good_rd;
  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = a_ready;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = d_valid & rq_head.is_read ? AccessAckData : AccessAck;
    tl_o.d_size   = d_valid ? rq_head.size : '0;
    tl_o.d_source = d_valid ? rq_head.source : '0;
    tl_o.d_data   = ~d_valid | ~rq_head.is_read ? '0 : rq_head.err ? '1 : rd_head[SramDw:1];
    tl_o.d_error  = d_valid & (rq_head.err | (good_rd & rd_head[0]));
  end
  assign unused_sig = ^{tl_i.a_param, rd_wready};
endmodule

// File: tb/tb_tlul_sram_bridge.sv
// tb_tlul_sram_bridge: directed scoreboard bench for tlul_sram_bridge.
module tb_tlul_sram_bridge;
  import tlul_pkg::*;
  typedef struct packed {
    tl_d_op_e    op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
  } rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tlul_sram_bridge_if bus ();
  tlul_sram_bridge dut (
    .clk_i(clk), .rst_i(rst), .tl_i(bus.h2d), .tl_o(bus.d2h),
    .req_o(bus.req), .gnt_i(bus.gnt), .we_o(bus.we), .addr_o(bus.addr),
    .wdata_o(bus.wdata), .wmask_o(bus.wmask), .rdata_i(bus.rdata),
    .rvalid_i(bus.rvalid), .rerror_i(bus.rerror)
  );
  rsp_t sb[$];
  logic [31:0] sram [1024];
  logic [31:0] ref_m [1024];
  int errors = 0;
  int checks = 0;
  logic auto_rsp, g_rd, acc, ar, rq, dv;
  logic [9:0] rd_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: observe at negedge (monitor + SRAM model), then drive SRAM reply after posedge
  task automatic tick();
    rsp_t e;
    @(negedge clk);
    ar = bus.d2h.a_ready;
    rq = bus.req;
    dv = bus.d2h.d_valid;
    acc = bus.h2d.a_valid & ar;
    g_rd = bus.req & bus.gnt & ~bus.we;
    rd_addr = bus.addr;
    if (bus.req & bus.gnt & bus.we) sram[bus.addr] = (sram[bus.addr] & ~bus.wmask) | (bus.wdata & bus.wmask);
    if (dv & bus.h2d.d_ready) begin
      chk("rsp_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("d_opcode", bus.d2h.d_opcode, e.op);
        chk("d_size", bus.d2h.d_size, e.size);
        chk("d_source", bus.d2h.d_source, e.src);
        chk("d_data", bus.d2h.d_data, e.data);
        chk("d_error", bus.d2h.d_error, e.err);
        chk("d_param_sink", {bus.d2h.d_param, bus.d2h.d_sink}, 0);
      end
    end
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      bus.rvalid = g_rd;
      bus.rdata = sram[rd_addr];
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                       input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    bus.h2d.a_valid = 1'b1;
    bus.h2d.a_opcode = tl_a_op_e'(op);
    bus.h2d.a_param = 3'd0;
    bus.h2d.a_size = size;
    bus.h2d.a_source = src;
    bus.h2d.a_address = addr;
    bus.h2d.a_mask = mask;
    bus.h2d.a_data = data;
  endtask

  task automatic expect_rsp(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                            input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src, input logic e);
    rsp_t r;
    logic [31:0] bm;
    bm = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    r.op = op == 3'd4 ? AccessAckData : AccessAck;
    r.size = size;
    r.src = src;
    r.err = e;
    r.data = op != 3'd4 ? 32'h0 : e ? 32'hFFFF_FFFF : ref_m[addr[11:2]];
    if (!e && op != 3'd4) ref_m[addr[11:2]] = (ref_m[addr[11:2]] & ~bm) | (data & bm);
    sb.push_back(r);
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                      input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src, input logic e);
    drive(op, addr, size, mask, data, src);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) tick();
    chk("accept", acc, 1);
    if (acc) expect_rsp(op, addr, size, mask, data, src, e);
    bus.h2d.a_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i] = i * 32'h9E37_79B1;
      ref_m[i] = i * 32'h9E37_79B1;
    end
    auto_rsp = 1'b1;
    bus.h2d = '0;
    bus.h2d.d_ready = 1'b1;
    bus.gnt = 1'b1;
    bus.rvalid = 1'b0;
    bus.rdata = '0;
    bus.rerror = '0;
    tick();
    tick();
    chk("rst_d_valid", bus.d2h.d_valid, 0);
    chk("rst_d_fields", {bus.d2h.d_opcode, bus.d2h.d_size, bus.d2h.d_source, bus.d2h.d_error}, 0);
    chk("rst_d_data", bus.d2h.d_data, 0);
    chk("rst_a_ready", bus.d2h.a_ready, 1);
    chk("rst_sram_idle", {bus.req, bus.we, bus.addr}, 0);
    chk("rst_wmask", bus.wmask, 0);
    rst = 1'b0;
    tick();
    // Full-word write
    drive(3'd0, 32'h10, 2'd2, 4'hF, 32'hDEAD_BEEF, 8'd3);
    #1;
    chk("wr_req", {bus.req, bus.we}, 2'b11);
    chk("wr_addr", bus.addr, 4);
    chk("wr_wmask", bus.wmask, 32'hFFFF_FFFF);
    chk("wr_wdata", bus.wdata, 32'hDEAD_BEEF);
    send(3'd0, 32'h10, 2'd2, 4'hF, 32'hDEAD_BEEF, 8'd3, 1'b0);
    tick();
    chk("wr_ack_next_cycle", dv, 1);
    // Read back with one-cycle SRAM latency
    send(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'd5, 1'b0);
    tick();
    chk("rd_lat_n1", dv, 0);
    tick();
    chk("rd_lat_n2", dv, 1);
    tick();
    // Backpressure with two outstanding
    bus.h2d.d_ready = 1'b0;
    drive(3'd4, 32'h14, 2'd2, 4'hF, 32'h0, 8'd1);
    tick();
    chk("bp_acc_a", acc, 1);
    expect_rsp(3'd4, 32'h14, 2'd2, 4'hF, 32'h0, 8'd1, 1'b0);
    drive(3'd4, 32'h18, 2'd2, 4'hF, 32'h0, 8'd2);
    tick();
    chk("bp_acc_b", acc, 1);
    expect_rsp(3'd4, 32'h18, 2'd2, 4'hF, 32'h0, 8'd2, 1'b0);
    drive(3'd4, 32'h1C, 2'd2, 4'hF, 32'h0, 8'd3);
    tick();
    chk("bp_full_a_ready", ar, 0);
    chk("bp_full_req", rq, 0);
    bus.h2d.d_ready = 1'b1;
    tick();
    chk("bp_pop_no_same_cycle_slot", acc, 0);
    tick();
    chk("bp_acc_c", acc, 1);
    expect_rsp(3'd4, 32'h1C, 2'd2, 4'hF, 32'h0, 8'd3, 1'b0);
    bus.h2d.a_valid = 1'b0;
    repeat (4) tick();
    // Malformed requests
    drive(3'd0, 32'h2, 2'd2, 4'hF, 32'h11, 8'd6);
    #1;
    chk("misalign_req", bus.req, 0);
    send(3'd0, 32'h2, 2'd2, 4'hF, 32'h11, 8'd6, 1'b1);
    tick();
    chk("err_ack_next_cycle", dv, 1);
    send(3'd7, 32'h20, 2'd2, 4'hF, 32'h0, 8'd7, 1'b1);
    send(3'd4, 32'h1000, 2'd2, 4'hF, 32'h0, 8'd8, 1'b1);
    send(3'd4, 32'h24, 2'd2, 4'h0, 32'h0, 8'd11, 1'b1);
    send(3'd4, 32'h20, 2'd3, 4'hF, 32'h0, 8'd14, 1'b1);
    send(3'd0, 32'h22, 2'd0, 4'b0010, 32'h0, 8'd13, 1'b1);
    // Partial and byte writes, then read-back
    send(3'd1, 32'h20, 2'd2, 4'b0011, 32'hA5A5_1234, 8'd9, 1'b0);
    send(3'd0, 32'h21, 2'd0, 4'b0010, 32'h0000_7700, 8'd12, 1'b0);
    send(3'd4, 32'h20, 2'd2, 4'hF, 32'h0, 8'd10, 1'b0);
    repeat (3) tick();
    // Read with SRAM error
    bus.rerror = 2'b01;
    send(3'd4, 32'h14, 2'd2, 4'hF, 32'h0, 8'd18, 1'b0);
    sb[sb.size()-1].err = 1'b1;
    repeat (3) tick();
    bus.rerror = 2'b00;
    // Back-to-back throughput
    drive(3'd0, 32'h30, 2'd2, 4'hF, 32'h3030_3030, 8'd20);
    tick();
    chk("tput_acc_0", acc, 1);
    expect_rsp(3'd0, 32'h30, 2'd2, 4'hF, 32'h3030_3030, 8'd20, 1'b0);
    drive(3'd0, 32'h34, 2'd2, 4'hF, 32'h3434_3434, 8'd21);
    tick();
    chk("tput_acc_1", acc, 1);
    expect_rsp(3'd0, 32'h34, 2'd2, 4'hF, 32'h3434_3434, 8'd21, 1'b0);
    bus.h2d.a_valid = 1'b0;
    repeat (3) tick();
    // SRAM stall
    bus.gnt = 1'b0;
    drive(3'd0, 32'h24, 2'd2, 4'hF, 32'h0BAD_F00D, 8'd15);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_a_ready", ar, 0);
      chk("stall_no_rsp", dv, 0);
    end
    bus.gnt = 1'b1;
    send(3'd0, 32'h24, 2'd2, 4'hF, 32'h0BAD_F00D, 8'd15, 1'b0);
    tick();
    chk("stall_ack", dv, 1);
    repeat (2) tick();
    // Reset while a read is waiting for rvalid, then a late straggler beat
    auto_rsp = 1'b0;
    send(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'd16, 1'b0);
    rst = 1'b1;
    sb.delete();
    tick();
    chk("rst_mid_d_valid", dv, 0);
    rst = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = 32'h1234_5678;
    tick();
    bus.rvalid = 1'b0;
    tick();
    chk("straggler_no_rsp_0", dv, 0);
    tick();
    chk("straggler_no_rsp_1", dv, 0);
    auto_rsp = 1'b1;
    send(3'd4, 32'h24, 2'd2, 4'hF, 32'h0, 8'd17, 1'b0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tlul_sram_bridge.md
# tlul_sram_bridge

Device-side TL-UL endpoint that sits directly downstream of `tlul_socket_m1` on its `tl_d_o`/`tl_d_i` port. It converts TL-UL Get/PutFullData/PutPartialData requests into single-port SRAM request/grant transactions. It tracks up to `Outstanding` requests and returns in-order AccessAck/AccessAckData responses. Malformed requests are answered with `d_error` and never reach the SRAM.

## Interface
Parameters:
- `SramAw`, default 10, SRAM word-address width.
- `SramDw`, default 32, SRAM data width; fixed equal to `tlul_pkg::TL_DW`.
- `Outstanding`, default 2, maximum number of accepted but unanswered requests (1..8).

Ports (one clock domain; reset is asynchronous and active-high):
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `tl_i` input `tl_h2d_t`: TL-UL request from the socket.
- `tl_o` output `tl_d2h_t`: TL-UL response to the socket.
- `req_o` output 1: SRAM request.
- `gnt_i` input 1: SRAM grant; a request transfers on `req_o & gnt_i`.
- `we_o` output 1: write enable.
- `addr_o` output `SramAw`: word address, `a_address[SramAw+1:2]`.
- `wdata_o` output `SramDw`: write data, `a_data`.
- `wmask_o` output `SramDw`: bit-expanded `a_mask`.
- `rdata_i` input `SramDw`: read data.
- `rvalid_i` input 1: read data valid, in order, at least 1 cycle after grant.
- `rerror_i` input 2: read error; any bit set gives `d_error`.

## Operation
- Request check, combinational on `tl_i`; `err` is the OR of:
  - opcode not in {Get=4, PutFullData=0, PutPartialData=1};
  - `a_size` > 2;
  - `a_address` not aligned to `a_size`;
  - `a_address[31:SramAw+2]` ≠ 0;
  - PutFullData whose mask is not all-ones over the addressed bytes;
  - Get or Put with `a_mask` = 0.
- `full`: request FIFO count equals `Outstanding`.
- `req_o = a_valid & ~err & ~full`. `we_o` = 1 for Put opcodes.
- `a_ready = ~full & (err | gnt_i)`.
- Errored requests are accepted without an SRAM access.
- Request FIFO, depth `Outstanding`, registered (no pass-through). Each entry holds `{is_read, err, a_size, a_source}`. Push on `a_valid & a_ready`.
- Read data FIFO, depth `Outstanding`, registered. It holds `{rdata, rerr}`.
  - Push on `rvalid_i` when `rd_pending` > 0.
  - `rd_pending` increments on a granted read and decrements on a pushed `rvalid_i`.
  - `rvalid_i` with `rd_pending` = 0 is ignored; this covers post-reset stragglers.
- Response generation, from the request FIFO head:
  - `d_valid` = head valid & (`~is_read` | `err` | data FIFO not empty).
  - `d_opcode` = AccessAckData(1) if `is_read`, else AccessAck(0).
  - `d_size` and `d_source` are echoed from the head entry.
  - `d_param` = 0, `d_sink` = 0.
  - `d_data` = FIFO data for a good read, all-ones for an errored read, 0 for writes.
  - `d_error` = `err` | `rerr`.
- Pop on `d_valid & d_ready`. The data FIFO pops together with the head only when the head is a non-errored read.
- Once `d_valid` is asserted, it and all `d_*` fields hold stable until `d_ready`.

## Timing
- Reset values: `tl_o.d_valid` 0, all other `d_*` fields 0. `tl_o.a_ready` is 1 when `tl_i` is idle and error-free; it has no registered state. FIFOs are empty and `rd_pending` is 0. SRAM outputs are combinational and 0 when `a_valid` = 0.
- `req_o`, `addr_o`, `wdata_o`, `wmask_o` and `we_o` are combinational from `tl_i`, with zero cycles of latency.
- Write or errored request accepted in cycle N: `d_valid` in N+1.
- Read granted in N with `rvalid_i` in N+L: `d_valid` in N+L+1.
- Full: `a_ready` = 0 and `req_o` = 0. A pop in the same cycle does not free a slot until the next cycle.
- Simultaneous push and pop on a non-full FIFO: both occur, count unchanged.
- Reset mid-operation: both FIFOs clear immediately, `rd_pending` clears, and any in-flight response is dropped.
- Throughput: one request per cycle while there is FIFO space and `gnt_i` = 1.

## Structure
- `tlul_pkg` holds the `tl_h2d_t`/`tl_d2h_t` types, `TL_DW`, `TL_AIW`, and the opcode enums (Get, PutFullData, PutPartialData, AccessAck, AccessAckData).
- The request FIFO and the read data FIFO are each an instance of `prim_fifo_sync` (Pass=0, Depth=`Outstanding`).
- Error check, `rd_pending` counter and response mux live in the top module.

## Test plan
- Write: PutFullData to 0x10, data 0xDEADBEEF, mask 0xF, `gnt_i` = 1 → `addr_o` = 4, `wmask_o` = 0xFFFFFFFF; AccessAck with `d_error` = 0 in the next cycle.
- Read: Get to 0x10 with `rvalid_i` one cycle after grant and `rdata_i` = 0xDEADBEEF → AccessAckData carrying 0xDEADBEEF two cycles after acceptance; `d_source` echoed.
- Backpressure: `Outstanding` = 2, `d_ready` = 0, three back-to-back Gets → third sees `a_ready` = 0. Raising `d_ready` frees a slot and the third is accepted; responses come back in order.
- Errors:
  - address 0x2 with size 2 (misaligned) → `req_o` = 0; AccessAck with `d_error` = 1 in the next cycle;
  - Get with opcode 7 → `d_error` = 1;
  - Get to an address beyond `SramAw` → AccessAckData with data 0xFFFFFFFF and `d_error` = 1.
- SRAM stall: `gnt_i` held 0 for 3 cycles on a valid Put → `a_ready` = 0 and no FIFO push until grant.
- Reset during a pending read: assert `rst_i` after grant and before `rvalid_i` → `d_valid` stays 0, and the late `rvalid_i` is ignored.
